// File: rtl/univ_shift_reg.sv
// Universal shift register: hold, shift right, shift left and parallel load, with serial taps.
// Define UNIV_SHIFT_REG_CNT_EN to build the valid-bit counter that drives full and done.
module univ_shift_reg #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic [1:0]       mode,
   input  logic             in,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q,
   output logic             sout_lsb,
   output logic             sout_msb,
   output logic             full,
   output logic             done
);

   localparam logic [1:0] MODE_HOLD  = 2'b00;
   localparam logic [1:0] MODE_RIGHT = 2'b01;
   localparam logic [1:0] MODE_LEFT  = 2'b10;
   localparam logic [1:0] MODE_LOAD  = 2'b11;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q <= '0;
      end else if (clr) begin
         q <= '0;
      end else begin
         case (mode)
            MODE_RIGHT: q <= {in, q[WIDTH-1:1]};
            MODE_LEFT:  q <= {q[WIDTH-2:0], in};
            MODE_LOAD:  q <= d;
            default:    q <= q;
         endcase
      end
   end

   assign sout_lsb = q[0];
   assign sout_msb = q[WIDTH-1];

`ifdef UNIV_SHIFT_REG_CNT_EN
   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);

   logic [CW-1:0] cnt;
   logic          shift;

   function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
      return (c == CNT_MAX) ? c : c + 1'b1;
   endfunction

   assign shift = (mode == MODE_RIGHT) || (mode == MODE_LEFT);

   // cnt tracks valid bits; done fires only on the WIDTH-1 -> WIDTH transition
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt  <= '0;
         full <= 1'b0;
         done <= 1'b0;
      end else if (clr) begin
         cnt  <= '0;
         full <= 1'b0;
         done <= 1'b0;
      end else if (mode == MODE_LOAD) begin
         cnt  <= CNT_MAX;
         full <= 1'b1;
         done <= 1'b0;
      end else if (shift) begin
         cnt  <= sat_inc(cnt);
         full <= (sat_inc(cnt) == CNT_MAX);
         done <= (cnt == CNT_MAX - CW'(1));
      end else begin
         done <= 1'b0;
      end
   end
`else
   assign full = 1'b0;
   assign done = 1'b0;
`endif

   // MODE_HOLD is handled by the default arms above
   localparam logic [1:0] UNUSED_HOLD = MODE_HOLD;

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed bench for univ_shift_reg: a 4-bit instance for the main scenarios and an 8-bit instance.
module tb_univ_shift_reg;

   localparam bit CNT_ON =
`ifdef UNIV_SHIFT_REG_CNT_EN
      1'b1;
`else
      1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       clr = 1'b0;
   logic [1:0] mode = 2'b00;
   logic       in = 1'b0;
   logic [3:0] d = 4'h0;
   logic [3:0] q;
   logic       sout_lsb, sout_msb, full, done;

   logic [1:0] mode8 = 2'b00;
   logic       in8 = 1'b0;
   logic [7:0] d8 = 8'h00;
   logic [7:0] q8;
   logic       sout_lsb8, sout_msb8, full8, done8;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   univ_shift_reg #(.WIDTH(4)) dut (
      .clk(clk), .rst_n(rst_n), .clr(clr), .mode(mode), .in(in), .d(d),
      .q(q), .sout_lsb(sout_lsb), .sout_msb(sout_msb), .full(full), .done(done)
   );

   univ_shift_reg #(.WIDTH(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .clr(1'b0), .mode(mode8), .in(in8), .d(d8),
      .q(q8), .sout_lsb(sout_lsb8), .sout_msb(sout_msb8), .full(full8), .done(done8)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step(input logic [1:0] m, input logic i, input logic [3:0] dv);
      mode = m;
      in   = i;
      d    = dv;
      @(posedge clk);
      #1;
   endtask

   task automatic check4(input string tag, input logic [3:0] eq, input bit ef, input bit ed);
      chk({tag, ".q"}, 32'(q), 32'(eq));
      chk({tag, ".full"}, 32'(full), 32'(CNT_ON & ef));
      chk({tag, ".done"}, 32'(done), 32'(CNT_ON & ed));
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      // power-on reset
      #2;
      chk("por.q", 32'(q), 32'h0);
      chk("por.full", 32'(full), 32'h0);
      chk("por.done", 32'(done), 32'h0);
      chk("por.q8", 32'(q8), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      // shift right 1,0,0,0 then one more shift while full
      step(2'b01, 1'b1, 4'h0); check4("sr1", 4'b1000, 0, 0);
      step(2'b01, 1'b0, 4'h0); check4("sr2", 4'b0100, 0, 0);
      step(2'b01, 1'b0, 4'h0); check4("sr3", 4'b0010, 0, 0);
      step(2'b01, 1'b0, 4'h0); check4("sr4", 4'b0001, 1, 1);
      chk("sr4.lsb", 32'(sout_lsb), 32'h1);
      chk("sr4.msb", 32'(sout_msb), 32'h0);
      step(2'b01, 1'b1, 4'h0); check4("sr5", 4'b1000, 1, 0);
      step(2'b00, 1'b0, 4'h0); check4("sr_hold", 4'b1000, 1, 0);

      // shift left 1,0,1,1
      pulse_reset();
      chk("rst2.q", 32'(q), 32'h0);
      step(2'b10, 1'b1, 4'h0); check4("sl1", 4'b0001, 0, 0);
      step(2'b10, 1'b0, 4'h0); check4("sl2", 4'b0010, 0, 0);
      step(2'b10, 1'b1, 4'h0); check4("sl3", 4'b0101, 0, 0);
      step(2'b10, 1'b1, 4'h0); check4("sl4", 4'b1011, 1, 1);
      chk("sl4.msb", 32'(sout_msb), 32'h1);

      // load then hold: no done pulse
      step(2'b11, 1'b0, 4'b1010); check4("ld", 4'b1010, 1, 0);
      for (int k = 0; k < 3; k++) begin
         step(2'b00, 1'b1, 4'b0101); check4("ld_hold", 4'b1010, 1, 0);
      end

      // clear beats load, then 4 shifts to refill
      pulse_reset();
      step(2'b01, 1'b1, 4'h0); check4("c_sr1", 4'b1000, 0, 0);
      step(2'b01, 1'b1, 4'h0); check4("c_sr2", 4'b1100, 0, 0);
      clr = 1'b1;
      step(2'b11, 1'b0, 4'b1111); check4("clr", 4'b0000, 0, 0);
      clr = 1'b0;
      step(2'b01, 1'b1, 4'h0); check4("c_a1", 4'b1000, 0, 0);
      step(2'b01, 1'b1, 4'h0); check4("c_a2", 4'b1100, 0, 0);
      step(2'b01, 1'b1, 4'h0); check4("c_a3", 4'b1110, 0, 0);
      step(2'b01, 1'b1, 4'h0); check4("c_a4", 4'b1111, 1, 1);

      // direction changes keep the count
      pulse_reset();
      step(2'b01, 1'b1, 4'h0); check4("dir1", 4'b1000, 0, 0);
      step(2'b10, 1'b1, 4'h0); check4("dir2", 4'b0001, 0, 0);
      step(2'b01, 1'b0, 4'h0); check4("dir3", 4'b0000, 0, 0);
      step(2'b10, 1'b1, 4'h0); check4("dir4", 4'b0001, 1, 1);

      // asynchronous reset between edges mid-fill
      pulse_reset();
      step(2'b01, 1'b1, 4'h0); check4("ar1", 4'b1000, 0, 0);
      step(2'b01, 1'b1, 4'h0); check4("ar2", 4'b1100, 0, 0);
      step(2'b01, 1'b1, 4'h0); check4("ar3", 4'b1110, 0, 0);
      #2;
      rst_n = 1'b0;
      #1;
      check4("ar_async", 4'b0000, 0, 0);
      #1;
      rst_n = 1'b1;
      step(2'b01, 1'b1, 4'h0); check4("ar_b1", 4'b1000, 0, 0);
      step(2'b01, 1'b0, 4'h0); check4("ar_b2", 4'b0100, 0, 0);
      step(2'b01, 1'b1, 4'h0); check4("ar_b3", 4'b1010, 0, 0);
      step(2'b01, 1'b1, 4'h0); check4("ar_b4", 4'b1101, 1, 1);
      mode = 2'b00;

      // 8-bit instance: alternating 1/0 shifted right, first bit lands in q[0]
      pulse_reset();
      mode8 = 2'b01;
      for (int k = 1; k <= 8; k++) begin
         in8 = (k % 2 == 1);
         @(posedge clk);
         #1;
         chk("w8.full", 32'(full8), 32'(CNT_ON && k == 8));
         chk("w8.done", 32'(done8), 32'(CNT_ON && k == 8));
         if (k == 4) chk("w8.q4", 32'(q8), 32'h50);
      end
      chk("w8.q8", 32'(q8), 32'h55);
      mode8 = 2'b00;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/univ_shift_reg.md
UNIV_SHIFT_REG -- requirements
Module: univ_shift_reg

Interface
REQ-001 Parameter: WIDTH, 4, register width in bits; legal range 2..32.
REQ-002 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: clr  input  1  synchronous clear.
REQ-005 Port: mode  input  2  operation select: 00 hold, 01 shift right, 10 shift left, 11 parallel load.
REQ-006 Port: in  input  1  serial data in.
REQ-007 Port: d  input  WIDTH  parallel load data.
REQ-008 Port: q  output  WIDTH  register contents.
REQ-009 Port: sout_lsb  output  1  serial out, equals q[0], combinational from q.
REQ-010 Port: sout_msb  output  1  serial out, equals q[WIDTH-1], combinational from q.
REQ-011 Port: full  output  1  high when WIDTH valid bits are held since the last clear, load or reset.
REQ-012 Port: done  output  1  one-cycle pulse when the shift count reaches WIDTH.

Function
REQ-013 Shift right (01) SHALL set q <= {in, q[WIDTH-1:1]}; the bit previously in q[0] is discarded.
REQ-014 Shift left (10) SHALL set q <= {q[WIDTH-2:0], in}; the bit previously in q[WIDTH-1] is discarded.
REQ-015 Load (11) SHALL set q <= d in one cycle, with no other latency.
REQ-016 Hold (00) SHALL leave q, the counter, full and done unchanged, except that done is forced to 0.
REQ-017 The internal counter cnt (width clog2(WIDTH+1)) SHALL count valid bits: +1 per shift, saturating at WIDTH.
REQ-018 full SHALL be registered, with full = (cnt == WIDTH).
REQ-019 done SHALL be 1 for exactly the cycle after a shift edge that moves cnt from WIDTH-1 to WIDTH, and 0 otherwise.
REQ-020 Load SHALL set cnt to WIDTH and full to 1, and SHALL NOT pulse done.
REQ-021 A shift while full SHALL keep cnt at WIDTH and full at 1, SHALL NOT pulse done, and SHALL continue to discard the oldest bit.
REQ-022 clr SHALL take priority over every mode, setting q, cnt, full and done to 0 at the next edge.
REQ-023 Mode changes between consecutive cycles SHALL be legal and take effect on the next edge; cnt carries over across direction changes.

Reset
REQ-024 rst_n low SHALL immediately force q=0, cnt=0, full=0 and done=0, independent of clk.
REQ-025 Reset asserted mid-shift SHALL discard all partial data; after release, counting restarts from 0.
REQ-026 rst_n deassertion SHALL be synchronised externally; the first active edge after release SHALL obey mode normally.

Configuration
REQ-027 Macro UNIV_SHIFT_REG_CNT_EN SHALL gate the valid-bit counter.
REQ-028 With UNIV_SHIFT_REG_CNT_EN defined, cnt, full and done SHALL behave per REQ-017 to REQ-022.
REQ-029 Without UNIV_SHIFT_REG_CNT_EN, no counter SHALL be built, full and done SHALL be tied to 0, and q behaviour SHALL be unchanged.

Verification (WIDTH=4, UNIV_SHIFT_REG_CNT_EN defined unless stated)
REQ-030 Reset, then mode=01 with in=1,0,0,0 over 4 edges -> q=1000,0100,0010,0001; full=1 and done=1 after the 4th edge; done=0 after the 5th.
REQ-031 Reset, then mode=10 with in=1,0,1,1 -> q=0001,0010,0101,1011; sout_msb=1 at the end; full=1.
REQ-032 mode=11 with d=1010, then mode=00 for 3 cycles -> q=1010 throughout, full=1, done never asserted.
REQ-033 Two right shifts, then clr=1 with mode=11 and d=1111 -> q=0000, full=0; 4 further shifts are needed to reach full.
REQ-034 rst_n pulsed low between edges after 3 shifts -> q=0000 and full=0 immediately; 4 shifts are needed afterwards for done.
REQ-035 Build without UNIV_SHIFT_REG_CNT_EN and with WIDTH=8; 8 right shifts of alternating 1/0 starting with 1 -> q=01010101 (first bit at q[0]); full=0 and done=0 throughout.
